// File: rtl/mcu_pkg.sv
// Shared encodings for the 8-bit MCU: instruction fields, SM/Op codes,
// sequencer phases and controller state types.
package mcu_pkg;

  typedef enum logic [1:0] {
    SM_MEM   = 2'b00,
    SM_ARITH = 2'b01,
    SM_LOGIC = 2'b10,
    SM_FLOW  = 2'b11
  } sm_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    WB_RES  = 1'b0,
    WB_DMEM = 1'b1
  } wb_src_e;

  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam logic [3:0] OP_LDM = 4'b0001;
  localparam logic [3:0] OP_STM = 4'b0010;

  localparam logic [3:0] OP_CMP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;

  localparam logic [3:0] OP_JMP = 4'b0000;
  localparam logic [3:0] OP_JNZ = 4'b0001;
  localparam logic [3:0] OP_JZ  = 4'b0010;
  localparam logic [3:0] OP_JNC = 4'b0011;
  localparam logic [3:0] OP_JC  = 4'b0100;

  localparam logic [2:0] PH_FETCH  = 3'd0;
  localparam logic [2:0] PH_DECODE = 3'd1;
  localparam logic [2:0] PH_EXEC   = 3'd2;
  localparam logic [2:0] PH_ALU    = 3'd3;
  localparam logic [2:0] PH_MEM    = 3'd4;
  localparam logic [2:0] PH_WB     = 3'd5;

  localparam int SM_HI  = 15;
  localparam int SM_LO  = 14;
  localparam int OP_HI  = 13;
  localparam int OP_LO  = 10;
  localparam int RD_HI  = 9;
  localparam int RD_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;

  function automatic logic [15:0] mk_instr(input logic [1:0] sm, input logic [3:0] op,
                                           input logic [1:0] rd, input logic [7:0] imm);
    return {sm, op, rd, imm};
  endfunction

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder: turns the latched instruction word into
// the control qualifiers the sequencer acts on in phases 2..5.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        wb_en,
  output wb_src_e     wb_src,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        upd_Z,
  output logic        upd_C,
  output logic        is_cmp,
  output logic        is_branch,
  output logic        imm_sel
);

  sm_e        sm;
  logic [3:0] op;
  logic       unused_ir;

  assign sm        = sm_e'(ir[SM_HI:SM_LO]);
  assign op        = ir[OP_HI:OP_LO];
  assign unused_ir = ^ir[RD_HI:0];

  // Anything not matched below stays all-zero, which makes it a NOP.
  always_comb begin
    wb_en     = 1'b0;
    wb_src    = WB_RES;
    dmem_rd   = 1'b0;
    dmem_wr   = 1'b0;
    upd_Z     = 1'b0;
    upd_C     = 1'b0;
    is_cmp    = 1'b0;
    is_branch = 1'b0;
    imm_sel   = (sm == SM_MEM) || (sm == SM_FLOW);
    case (sm)
      SM_MEM: begin
        case (op)
          OP_LDI: wb_en = 1'b1;
          OP_LDM: begin
            wb_en   = 1'b1;
            wb_src  = WB_DMEM;
            dmem_rd = 1'b1;
          end
          OP_STM:  dmem_wr = 1'b1;
          default: ;
        endcase
      end
      SM_ARITH: begin
        case (op)
          OP_CMP: begin
            is_cmp = 1'b1;
            upd_Z  = 1'b1;
            upd_C  = 1'b1;
          end
          OP_ADD: begin
            wb_en = 1'b1;
            upd_Z = 1'b1;
            upd_C = 1'b1;
          end
          OP_SUB: begin
            wb_en = 1'b1;
            upd_Z = 1'b1;
          end
          default: ;
        endcase
      end
      SM_LOGIC: begin
        if (op <= OP_NOT) begin
          wb_en = 1'b1;
          upd_Z = 1'b1;
        end
      end
      SM_FLOW: begin
        if (op <= OP_JC) is_branch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcu_seq_ctrl.sv
// Six-phase instruction sequencer: fetch, decode, execute via the shared ALU,
// memory access and writeback/PC update, one instruction per six clocks.
module mcu_seq_ctrl
  import mcu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int N    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [1:0]      rf_ra1,
  output logic [1:0]      rf_ra2,
  input  logic [N-1:0]    rf_rd1,
  input  logic [N-1:0]    rf_rd2,
  output logic [1:0]      rf_wa,
  output logic [N-1:0]    rf_wd,
  output logic            rf_we,
  output logic [7:0]      dmem_addr,
  output logic [N-1:0]    dmem_wdata,
  output logic            dmem_we,
  input  logic [N-1:0]    dmem_rdata,
  output logic [2:0]      cnt_clk,
  output logic [1:0]      alu_sm,
  output logic [3:0]      alu_op,
  output logic [N-1:0]    alu_rs1,
  output logic [N-1:0]    alu_rs2,
  input  logic [N-1:0]    alu_rd,
  input  logic [3:0]      alu_flag,
  output logic            flag_Z,
  output logic            flag_C,
  output logic            busy
);

  state_e          state, state_nx;
  logic [2:0]      phase, phase_nx;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [N-1:0]    res;
  logic [7:0]      imm8;
  logic            taken;
  logic            unused_flag;

  logic    wb_en, dmem_rd, dmem_wr, upd_Z, upd_C, is_cmp, is_branch, imm_sel;
  wb_src_e wb_src;

  mcu_decode u_decode (
    .ir        (ir),
    .wb_en     (wb_en),
    .wb_src    (wb_src),
    .dmem_rd   (dmem_rd),
    .dmem_wr   (dmem_wr),
    .upd_Z     (upd_Z),
    .upd_C     (upd_C),
    .is_cmp    (is_cmp),
    .is_branch (is_branch),
    .imm_sel   (imm_sel)
  );

  assign imm8        = ir[IMM_HI:IMM_LO];
  assign cnt_clk     = phase;
  assign busy        = (state == ST_RUN);
  assign unused_flag = ^alu_flag[2:1];

  // Branches look at the architectural flags, so a flag set by the previous
  // instruction's writeback is already visible here.
  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (ir[OP_HI:OP_LO])
        OP_JMP:  taken = 1'b1;
        OP_JNZ:  taken = ~flag_Z;
        OP_JZ:   taken = flag_Z;
        OP_JNC:  taken = ~flag_C;
        OP_JC:   taken = flag_C;
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    case (state)
      ST_IDLE: begin
        phase_nx = PH_FETCH;
        if (run) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (phase == PH_WB) begin
          phase_nx = PH_FETCH;
          if (!run) state_nx = ST_IDLE;
        end else begin
          phase_nx = phase + 3'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        phase_nx = PH_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      phase  <= PH_FETCH;
      pc     <= '0;
      ir     <= '0;
      res    <= '0;
      flag_Z <= 1'b0;
      flag_C <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      if (state == ST_RUN) begin
        if (phase == PH_DECODE) ir <= imem_data;
        if (phase == PH_MEM) res <= alu_rd;
        if (phase == PH_WB) begin
          pc <= taken ? PC_W'(imm8) : pc + PC_W'(1);
          if (is_cmp) begin
            flag_Z <= (rf_rd1 == rf_rd2);
            flag_C <= alu_flag[3];
          end else begin
            if (upd_Z) flag_Z <= (res == '0);
            if (upd_C) flag_C <= alu_flag[0];
          end
        end
      end
    end
  end

  // Strobes are masked by rst so a reset landing in phase 4/5 cancels the write.
  always_comb begin
    imem_addr  = '0;
    rf_ra1     = '0;
    rf_ra2     = '0;
    rf_wa      = '0;
    rf_wd      = '0;
    rf_we      = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_we    = 1'b0;
    alu_sm     = '0;
    alu_op     = '0;
    alu_rs1    = '0;
    alu_rs2    = '0;
    if (state == ST_RUN) begin
      if (phase >= PH_EXEC) begin
        rf_ra1 = ir[RD_HI:RD_LO];
        rf_ra2 = ir[RS2_HI:RS2_LO];
      end
      case (phase)
        PH_FETCH: imem_addr = pc;
        PH_EXEC: begin
          alu_sm  = ir[SM_HI:SM_LO];
          alu_op  = ir[OP_HI:OP_LO];
          alu_rs1 = rf_rd1;
          alu_rs2 = imm_sel ? N'(imm8) : rf_rd2;
        end
        PH_MEM: begin
          if (dmem_rd || dmem_wr) dmem_addr = imm8;
          if (dmem_wr) begin
            dmem_wdata = rf_rd1;
            dmem_we    = ~rst;
          end
        end
        PH_WB: begin
          if (wb_en) begin
            rf_we = ~rst;
            rf_wa = ir[RD_HI:RD_LO];
            rf_wd = (wb_src == WB_DMEM) ? dmem_rdata : res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_seq_ctrl.sv
// Directed bench for mcu_seq_ctrl with behavioural instruction memory,
// data memory, register file and a two-stage ALU model around it.
module tb_mcu_seq_ctrl;
  import mcu_pkg::*;

  localparam int PC_W = 8;
  localparam int N    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data = '0;
  logic [1:0]      rf_ra1, rf_ra2, rf_wa;
  logic [N-1:0]    rf_rd1, rf_rd2, rf_wd;
  logic            rf_we;
  logic [7:0]      dmem_addr;
  logic [N-1:0]    dmem_wdata;
  logic            dmem_we;
  logic [N-1:0]    dmem_rdata = '0;
  logic [2:0]      cnt_clk;
  logic [1:0]      alu_sm;
  logic [3:0]      alu_op;
  logic [N-1:0]    alu_rs1, alu_rs2;
  logic [N-1:0]    alu_rd = '0;
  logic [3:0]      alu_flag = '0;
  logic            flag_Z, flag_C, busy;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [7:0]  rf   [4];
  logic [1:0]  a_sm = '0;
  logic [3:0]  a_op = '0;
  logic [7:0]  a_rs1 = '0, a_rs2 = '0;
  logic [11:0] a_out;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  int dmem_writes = 0;

  mcu_seq_ctrl #(.PC_W(PC_W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_we      (rf_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .cnt_clk    (cnt_clk),
    .alu_sm     (alu_sm),
    .alu_op     (alu_op),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_rd     (alu_rd),
    .alu_flag   (alu_flag),
    .flag_Z     (flag_Z),
    .flag_C     (flag_C),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {ge, neg, zero, carry, result}.
  function automatic logic [11:0] aluModel(input logic [1:0] sm, input logic [3:0] op,
                                           input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    s = '0;
    case (sm)
      2'b00: r = b;
      2'b01: begin
        if (op == 4'd1) begin
          s = {1'b0, a} + {1'b0, b};
          r = s[7:0];
          c = s[8];
        end else begin
          r = a - b;
        end
      end
      2'b10: begin
        case (op)
          4'd0:    r = a & b;
          4'd1:    r = a | b;
          4'd2:    r = a ^ b;
          default: r = ~a;
        endcase
      end
      default: r = a;
    endcase
    return {(a >= b), r[7], (r == 8'h00), c, r};
  endfunction

  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];
  assign a_out  = aluModel(a_sm, a_op, a_rs1, a_rs2);

  always @(posedge clk) imem_data <= imem[imem_addr];

  always @(posedge clk) begin
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      dmem_writes     <= dmem_writes + 1;
    end
    dmem_rdata <= dmem[dmem_addr];
  end

  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

  // ALU samples its inputs at the end of phase 2 and registers the result at the end of phase 3.
  always @(posedge clk) begin
    if (busy && cnt_clk == 3'd2) begin
      a_sm  <= alu_sm;
      a_op  <= alu_op;
      a_rs1 <= alu_rs1;
      a_rs2 <= alu_rs2;
    end
    if (busy && cnt_clk == 3'd3) begin
      alu_rd   <= a_out[7:0];
      alu_flag <= a_out[11:8];
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rf_we && dmem_we) viol++;
    if (rf_we && !(busy && cnt_clk == 3'd5)) viol++;
    if (dmem_we && !(busy && cnt_clk == 3'd4)) viol++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end (errors so far %0d)", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rn);
    rst = r;
    run = rn;
  endtask

  task automatic waitPhase(input logic [2:0] p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (busy && cnt_clk == p) found = 1'b1;
    end
    if (!found) checkOutput("phase_timeout", {29'd0, cnt_clk}, {29'd0, p});
  endtask

  initial begin
    logic early;
    for (int i = 0; i < 256; i++) imem[i] = mk_instr(SM_FLOW, 4'hF, 2'd0, 8'h00);
    imem[8'h00] = mk_instr(SM_MEM,   OP_LDI, 2'd1, 8'h5A);
    imem[8'h01] = mk_instr(SM_MEM,   OP_LDI, 2'd1, 8'hF0);
    imem[8'h02] = mk_instr(SM_MEM,   OP_LDI, 2'd2, 8'h20);
    imem[8'h03] = mk_instr(SM_ARITH, OP_ADD, 2'd1, 8'h02);
    imem[8'h04] = mk_instr(SM_MEM,   OP_LDI, 2'd1, 8'h33);
    imem[8'h05] = mk_instr(SM_MEM,   OP_LDI, 2'd2, 8'h33);
    imem[8'h06] = mk_instr(SM_ARITH, OP_CMP, 2'd1, 8'h02);
    imem[8'h07] = mk_instr(SM_FLOW,  OP_JNZ, 2'd0, 8'h20);
    imem[8'h08] = mk_instr(SM_FLOW,  OP_JZ,  2'd0, 8'h40);
    imem[8'h40] = mk_instr(SM_MEM,   OP_LDI, 2'd3, 8'hA7);
    imem[8'h41] = mk_instr(SM_MEM,   OP_STM, 2'd3, 8'h80);
    imem[8'h42] = mk_instr(SM_MEM,   OP_LDM, 2'd0, 8'h80);
    imem[8'h43] = mk_instr(SM_FLOW,  OP_JMP, 2'd0, 8'hFF);

    applyStimulus(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cnt", cnt_clk, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    checkOutput("rst_flags", {flag_Z, flag_C}, 0);
    checkOutput("rst_strobes", {rf_we, dmem_we}, 0);

    // Ldi r1,#5A from pc 0: writeback lands in the sixth cycle after release.
    applyStimulus(1'b0, 1'b1);
    early = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c < 6) early = early | rf_we;
    end
    checkOutput("ldi_no_early_we", early, 0);
    checkOutput("ldi_phase", cnt_clk, 5);
    checkOutput("ldi_we", rf_we, 1);
    checkOutput("ldi_wa", rf_wa, 1);
    checkOutput("ldi_wd", rf_wd, 8'h5A);
    @(negedge clk);
    checkOutput("ldi_pc_next", imem_addr, 8'h01);

    // ADD r1,r2 with F0 + 20 carries out and leaves 0x10.
    waitPhase(5);
    waitPhase(5);
    waitPhase(5);
    checkOutput("add_we", rf_we, 1);
    checkOutput("add_wd", rf_wd, 8'h10);
    @(negedge clk);
    checkOutput("add_flag_C", flag_C, 1);
    checkOutput("add_flag_Z", flag_Z, 0);

    // CMP of equal operands, then JNZ not taken, JZ taken to 0x40.
    waitPhase(5);
    waitPhase(5);
    waitPhase(5);
    checkOutput("cmp_no_we", rf_we, 0);
    @(negedge clk);
    checkOutput("cmp_flag_Z", flag_Z, 1);
    checkOutput("cmp_flag_C", flag_C, 1);
    waitPhase(5);
    @(negedge clk);
    checkOutput("jnz_not_taken", imem_addr, 8'h08);
    waitPhase(5);
    @(negedge clk);
    checkOutput("jz_taken", imem_addr, 8'h40);

    // Ldi r3, then Stm r3 -> 0x80 and Ldm r0 <- 0x80.
    waitPhase(5);
    waitPhase(3);
    checkOutput("stm_we_ph3", dmem_we, 0);
    waitPhase(4);
    checkOutput("stm_we_ph4", dmem_we, 1);
    checkOutput("stm_addr", dmem_addr, 8'h80);
    checkOutput("stm_wdata", dmem_wdata, 8'hA7);
    waitPhase(5);
    checkOutput("stm_we_ph5", dmem_we, 0);
    checkOutput("stm_no_rf_we", rf_we, 0);
    waitPhase(5);
    checkOutput("ldm_we", rf_we, 1);
    checkOutput("ldm_wa", rf_wa, 0);
    checkOutput("ldm_wd", rf_wd, 8'hA7);

    // JMP 0xFF, NOP at 0xFF with run dropped in phase 3.
    waitPhase(5);
    @(negedge clk);
    checkOutput("jmp_ff", imem_addr, 8'hFF);
    waitPhase(3);
    applyStimulus(1'b0, 1'b0);
    waitPhase(5);
    checkOutput("nop_strobes", {rf_we, dmem_we}, 0);
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_cnt", cnt_clk, 0);
    repeat (3) @(negedge clk);
    checkOutput("idle_parked", busy, 0);

    // Restart: pc wrapped to 0x00; run through to the Stm again and reset in phase 4.
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("restart_busy", busy, 1);
    checkOutput("pc_wrap", imem_addr, 8'h00);
    repeat (10) waitPhase(5);
    waitPhase(4);
    checkOutput("stm2_we_pre", dmem_we, 1);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("rst_stm_we", dmem_we, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    @(negedge clk);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_cnt", cnt_clk, 0);
    checkOutput("post_rst_flags", {flag_Z, flag_C}, 0);
    checkOutput("post_rst_dmem", {dmem_addr, dmem_wdata}, 0);
    checkOutput("post_rst_alu", {alu_sm, alu_op, alu_rs1, alu_rs2}, 0);
    checkOutput("post_rst_rf", {rf_wa, rf_wd, rf_ra1, rf_ra2}, 0);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_pc", imem_addr, 8'h00);
    checkOutput("dmem_write_count", dmem_writes, 1);
    checkOutput("dmem_80", dmem[8'h80], 8'hA7);
    checkOutput("strobe_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_seq_ctrl.md
# mcu_seq_ctrl

Instruction sequencer for the 8-bit MCU core: it fetches, decodes and retires one instruction every six clocks, driving the shared ALU's phase counter and its mode/opcode/operand inputs. It also owns the register-file read/write ports, the data-memory strobes, the program counter and the Z/C flag registers. It sits between instruction memory, register file, data memory and the ALU instance. The ALU is built with `SIZE_CNT=2` and `CNT_CLK=2`.

## Interface
- `PC_W`, default 8: program-counter and instruction-memory address width.
- `N`, default 8: data width.
- `clk` in, 1: single clock; all state updates on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `run` in, 1: allows a new fetch; sampled only in phase 5 and in IDLE.
- `imem_addr` out, PC_W: instruction address.
- `imem_data` in, 16: instruction; synchronous read, valid one cycle after `imem_addr`.
- `rf_ra1`, `rf_ra2` out, 2: register-file read indices.
- `rf_rd1`, `rf_rd2` in, N: register-file read data; combinational read.
- `rf_wa` out, 2: register-file write index.
- `rf_wd` out, N: register-file write data.
- `rf_we` out, 1: register-file write strobe.
- `dmem_addr` out, 8: data-memory address.
- `dmem_wdata` out, N: data-memory write data.
- `dmem_we` out, 1: data-memory write strobe.
- `dmem_rdata` in, N: data-memory read data; synchronous, one-cycle latency.
- `cnt_clk` out, 3: phase count into the ALU.
- `alu_sm` out, 2: ALU mode.
- `alu_op` out, 4: ALU opcode.
- `alu_rs1`, `alu_rs2` out, N: ALU operands.
- `alu_rd` in, N: ALU result.
- `alu_flag` in, 4: ALU flags; bit0 is carry, bit3 is `rs1>=rs2`.
- `flag_Z`, `flag_C` out, 1: architectural flags; also wired back into the ALU.
- `busy` out, 1: high while an instruction is in flight.

## Operation
- Instruction fields:
  - `[15:14]` SM
  - `[13:10]` Op
  - `[9:8]` rd/rs1 index
  - `[7:0]` imm8
  - For register-form instructions, `[1:0]` of imm8 is the rs2 index.
- States: IDLE and RUN. In RUN, `cnt_clk` steps 0→5 and then wraps.
- Phase 0 (FETCH): drive `imem_addr = pc`.
- Phase 1 (DECODE): latch `imem_data` into `ir`. Drive `rf_ra1 = ir[9:8]` and `rf_ra2 = ir[1:0]`.
- Phase 2 (EXEC): drive `alu_sm`, `alu_op` and the operands.
  - `alu_rs1 = rf_rd1`.
  - `alu_rs2 = imm8` when SM is 00 or 11, otherwise `rf_rd2`.
  - The ALU samples at the end of this phase.
- Phase 3: ALU output register loads.
- Phase 4 (MEM): latch `alu_rd` into `res`.
  - Ldm (00/0001): `dmem_addr = imm8`; the read is issued.
  - Stm (00/0010): `dmem_addr = imm8`, `dmem_wdata = rf_rd1`, `dmem_we = 1` for exactly one cycle.
- Phase 5 (WB/PC):
  - Ldi: `rf_wd = res`.
  - Ldm: `rf_wd = dmem_rdata`.
  - Arithmetic and logic ops other than CMP: `rf_wd = res`.
  - `rf_we` pulses for one cycle with `rf_wa = ir[9:8]`.
- Flag updates in phase 5:
  - ADD: `C <= alu_flag[0]`, `Z <= (res==0)`.
  - SUB and all logic ops: `Z <= (res==0)`; C holds.
  - CMP (01/0000): no writeback; `Z <= (rf_rd1==rf_rd2)`, `C <= alu_flag[3]`.
- Flow control (SM=11). The branch decision uses the controller's own flags, not `alu_rd`. Target is imm8.
  - Op 0000: always taken.
  - Op 0001: taken if Z==0.
  - Op 0010: taken if Z==1.
  - Op 0011: taken if C==0.
  - Op 0100: taken if C==1.
- PC update in phase 5: `pc <= taken ? imm8 : pc+1`. The increment wraps 8'hFF→8'h00.
- Undefined SM/Op combinations are NOPs: no `rf_we`, no `dmem_we`, flags hold, `pc+1`.
- Phase 5 exit: if `run=1`, go to phase 0; otherwise go to IDLE.
- IDLE: `cnt_clk` holds 0 and `busy=0`. Entry to phase 0 occurs on the first clock with `run=1`.

## Timing
- Reset values: `pc=0`, IDLE, `cnt_clk=0`, `ir=0`, `flag_Z=0`, `flag_C=0`, `busy=0`. All strobes, addresses and data outputs are 0.
- Fixed latency of 6 clocks per instruction, with no stalls.
- Back-to-back instructions: the fetch for instruction k+1 is in the cycle after phase 5 of instruction k.
- `rf_we` and `dmem_we` are never high in the same cycle, and never high outside phases 4/5.
- Deasserting `run` mid-instruction does not abort it; the instruction completes and the controller then parks in IDLE.
- Reset asserted in any phase takes effect at that edge. A pending `rf_we` or `dmem_we` is suppressed, and pc returns to 0.
- A flag written in phase 5 is visible to a branch in the next instruction.

## Structure
- Shared package `mcu_pkg` holds:
  - SM encodings: MEM=00, ARITH=01, LOGIC=10, FLOW=11.
  - All Op codes.
  - Phase constants `PH_FETCH` through `PH_WB`.
  - Instruction field positions.
- One natural sub-module: `mcu_decode`, combinational. It maps `ir` to `wb_en`, `wb_src`, `dmem_rd`, `dmem_wr`, `upd_Z`, `upd_C`, `is_cmp`, `is_branch`, `imm_sel`.

## Test plan
- Ldi r1,#0x5A at pc 0 → `rf_we` in cycle 6 after reset release, with `rf_wa=1` and `rf_wd=0x5A`; pc becomes 1.
- r1=0xF0, r2=0x20, ADD r1,r2 → `rf_wd=0x10`, `flag_C=1`, `flag_Z=0`.
- r1=0x33, r2=0x33, CMP, then branch op 0010 to 0x40 → Z=1 and C=1, no `rf_we` on the CMP, and pc becomes 0x40 after the branch.
- Stm r3 to 0x80, then Ldm r0 from 0x80 → `dmem_we` is a one-cycle pulse in phase 4 with `dmem_wdata` equal to r3, and r0 is then written with the same value.
- pc=0xFF executing a NOP → pc becomes 0x00. With `run=0` during phase 3, the controller enters IDLE after phase 5 and `busy` drops.
- `rst` pulsed in phase 4 of an Stm → no `dmem_we`, pc=0, and all outputs return to their reset values.
